// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing generator (default 640x480, 800x525 totals).
// A pixel enable at half the clk_in rate steps the column/line counters; sync
// and active-video decodes are registered alongside the counters so they line
// up with the coordinates they describe.
// Optional: define FRAME_CNT_EN to add the 16-bit frame_cnt output and counter.
module vga_timing_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        run,
   output logic        pix_en,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  h_cnt,
   output logic [9:0]  v_cnt,
   output logic        frame_start,
   output logic        busy
`ifdef FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_e;

   state_e     state_q, state_d;
   logic       phase_q, phase_d;
   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       last_px;

   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       video_q, video_d;
   logic       fstart_q, fstart_d;
   logic       busy_q, busy_d;

   // Next state, pixel phase and raster position.
   always_comb begin
      state_d = state_q;
      phase_d = 1'b0;
      h_d     = h_q;
      v_d     = v_q;
      last_px = phase_q && (h_q == H_LAST) && (v_q == V_LAST);
      unique case (state_q)
         IDLE: begin
            h_d = '0;
            v_d = '0;
            if (run) begin
               state_d = ACTIVE;
            end
         end
         ACTIVE, DRAIN: begin
            phase_d = ~phase_q;
            if (phase_q) begin
               if (h_q == H_LAST) begin
                  h_d = '0;
                  v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
               end else begin
                  h_d = h_q + 10'd1;
               end
            end
            // The last-pixel exit is decided by the current state only, so a
            // run change on that same edge cannot rescue a draining frame.
            if (state_q == ACTIVE) begin
               if (!run) begin
                  state_d = DRAIN;
               end
            end else if (last_px) begin
               state_d = IDLE;
            end else if (run) begin
               state_d = ACTIVE;
            end
         end
         default: begin
            state_d = IDLE;
            h_d     = '0;
            v_d     = '0;
         end
      endcase
   end

   // Decodes computed from the next position so they register with it.
   always_comb begin
      busy_d   = (state_d != IDLE);
      hsync_d  = !(busy_d && (h_d >= HS_FIRST) && (h_d <= HS_LAST));
      vsync_d  = !(busy_d && (v_d >= VS_FIRST) && (v_d <= VS_LAST));
      video_d  = busy_d && (h_d < H_VIS) && (v_d < V_VIS);
      fstart_d = phase_d && (h_d == '0) && (v_d == '0);
   end

   // State, counters and registered outputs; reset forces the idle picture.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         phase_q  <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         video_q  <= 1'b0;
         fstart_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         h_q      <= h_d;
         v_q      <= v_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         video_q  <= video_d;
         fstart_q <= fstart_d;
         busy_q   <= busy_d;
      end
   end

   assign pix_en      = phase_q;
   assign h_cnt       = h_q;
   assign v_cnt       = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_q;
   assign frame_start = fstart_q;
   assign busy        = busy_q;

`ifdef FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Count completed frames; wraps naturally at 16 bits.
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         frame_cnt_q <= '0;
      end else if (last_px) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for vga_timing_ctrl on a shrunken raster
// (16x10 totals, 320 clk_in per frame). Stimulus pushes the cycle numbers at
// which frame_start, hsync/vsync edges and busy falls must appear; a monitor
// pops and compares them as the DUT produces those events.
module tb_vga_timing_ctrl;

   localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;

   localparam int K_FS = 0, K_HSF = 1, K_HSR = 2, K_VSF = 3, K_VSR = 4, K_BSF = 5;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        run;
   logic        pix_en, hsync, vsync, video_on, frame_start, busy;
   logic [9:0]  h_cnt, v_cnt;
`ifdef FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   vga_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
   ) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .run         (run),
      .pix_en      (pix_en),
      .hsync       (hsync),
      .vsync       (vsync),
      .video_on    (video_on),
      .h_cnt       (h_cnt),
      .v_cnt       (v_cnt),
      .frame_start (frame_start),
      .busy        (busy)
`ifdef FRAME_CNT_EN
      ,
      .frame_cnt   (frame_cnt)
`endif
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int exp_q[6][$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic ev(input int k, input string name);
      if (exp_q[k].size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: event at cycle %0d, none required", name, cyc);
      end else begin
         check(name, cyc, exp_q[k].pop_front());
      end
   endtask

   // Expected event cycles for a frame whose frame_start is at cycle f;
   // pixel p = h + 16*v is held on cycles f+2p-1 and f+2p.
   task automatic push_frame(input int f, input int lines);
      exp_q[K_FS].push_back(f);
      for (int l = 0; l < lines; l++) begin
         exp_q[K_HSF].push_back(f + 19 + 32 * l);
         exp_q[K_HSR].push_back(f + 25 + 32 * l);
      end
      if (lines == 10) begin
         exp_q[K_VSF].push_back(f + 223);
         exp_q[K_VSR].push_back(f + 287);
      end
   endtask

   task automatic at_cycle(input int c);
      if (cyc > c) begin
         checks++;
         errors++;
         $display("FAIL schedule: cycle %0d already past target %0d", cyc, c);
      end
      while (cyc < c) @(negedge clk_in);
   endtask

   task automatic spot(input string tag, input int c, input int h, input int v,
                       input logic vid, input logic hs, input logic vs);
      at_cycle(c);
      check({tag, ".h_cnt"}, h_cnt, h);
      check({tag, ".v_cnt"}, v_cnt, v);
      check({tag, ".video_on"}, video_on, vid);
      check({tag, ".hsync"}, hsync, hs);
      check({tag, ".vsync"}, vsync, vs);
   endtask

   task automatic idle_chk(input string tag);
      check({tag, ".h_cnt"}, h_cnt, 0);
      check({tag, ".v_cnt"}, v_cnt, 0);
      check({tag, ".pix_en"}, pix_en, 0);
      check({tag, ".hsync"}, hsync, 1);
      check({tag, ".vsync"}, vsync, 1);
      check({tag, ".video_on"}, video_on, 0);
      check({tag, ".frame_start"}, frame_start, 0);
      check({tag, ".busy"}, busy, 0);
   endtask

   // Monitor: pops an expected cycle for every observed event.
   logic p_hs = 1'b1, p_vs = 1'b1, p_busy = 1'b0;
   initial begin
      forever begin
         @(negedge clk_in);
         if (frame_start === 1'b1) begin
            ev(K_FS, "frame_start_cycle");
            check("frame_start.pix_en", pix_en, 1);
            check("frame_start.h_cnt", h_cnt, 0);
            check("frame_start.v_cnt", v_cnt, 0);
         end
         if (p_hs === 1'b1 && hsync === 1'b0) ev(K_HSF, "hsync_fall_cycle");
         if (p_hs === 1'b0 && hsync === 1'b1) ev(K_HSR, "hsync_rise_cycle");
         if (p_vs === 1'b1 && vsync === 1'b0) ev(K_VSF, "vsync_fall_cycle");
         if (p_vs === 1'b0 && vsync === 1'b1) ev(K_VSR, "vsync_rise_cycle");
         if (p_busy === 1'b1 && busy === 1'b0) ev(K_BSF, "busy_fall_cycle");
         p_hs   = hsync;
         p_vs   = vsync;
         p_busy = busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, f2, f3, f4, f5, f6, f7, f8;
      reset = 1'b1;
      run   = 1'b0;
      #2 reset = 1'b0;
      #1 idle_chk("por_async");
`ifdef FRAME_CNT_EN
      check("por.frame_cnt", frame_cnt, 0);
`endif
      @(negedge clk_in);
      #1 reset = 1'b1;
      at_cycle(cyc + 3);
      idle_chk("idle_no_run");

      // Three back-to-back frames from IDLE.
      #1 run = 1'b1;
      f0 = cyc + 2;
      push_frame(f0, 10);
      push_frame(f0 + 320, 10);
      push_frame(f0 + 640, 10);
      at_cycle(f0);
      check("first.pix_en", pix_en, 1);
      check("first.frame_start", frame_start, 1);
      check("first.busy", busy, 1);
      at_cycle(f0 + 1);
      check("second.pix_en", pix_en, 0);
      check("second.h_cnt", h_cnt, 1);
      spot("p1_0",  f0 + 2,   1, 0, 1, 1, 1);
      spot("p9_0",  f0 + 18,  9, 0, 0, 1, 1);
      spot("p10_0", f0 + 20, 10, 0, 0, 0, 1);
      spot("p12_1", f0 + 56, 12, 1, 0, 0, 1);
      spot("p13_1", f0 + 58, 13, 1, 0, 1, 1);
      spot("p7_5",  f0 + 174, 7, 5, 1, 1, 1);
      spot("p8_5",  f0 + 176, 8, 5, 0, 1, 1);
      spot("p7_6",  f0 + 206, 7, 6, 0, 1, 1);
      spot("p15_6", f0 + 222, 15, 6, 0, 1, 1);
      spot("p0_7",  f0 + 224, 0, 7, 0, 1, 0);
      spot("p15_8", f0 + 286, 15, 8, 0, 1, 0);
      spot("p0_9",  f0 + 288, 0, 9, 0, 1, 1);
`ifdef FRAME_CNT_EN
      at_cycle(f0 + 319);
      check("frame_cnt_1", frame_cnt, 1);
`endif

      // Drop run at (5,4) of the third frame: drain to the last pixel.
      f2 = f0 + 640;
      at_cycle(f2 + 138);
      #1 run = 1'b0;
      exp_q[K_BSF].push_back(f2 + 319);
      at_cycle(f2 + 318);
      check("drain_last.busy", busy, 1);
      check("drain_last.h_cnt", h_cnt, 15);
      check("drain_last.v_cnt", v_cnt, 9);
      at_cycle(f2 + 319);
      idle_chk("drain_end");
`ifdef FRAME_CNT_EN
      check("frame_cnt_3", frame_cnt, 3);
`endif
      at_cycle(f2 + 360);
      idle_chk("drain_hold");

      // Drop and re-raise run mid-frame: no discontinuity.
      #1 run = 1'b1;
      f3 = cyc + 2;
      push_frame(f3, 10);
      at_cycle(f3 + 70);
      #1 run = 1'b0;
      at_cycle(f3 + 150);
      check("drain_mid.busy", busy, 1);
      at_cycle(f3 + 210);
      #1 run = 1'b1;
      f4 = f3 + 320;
      push_frame(f4, 10);

      // DRAIN with run re-raised on the last-pixel edge still goes IDLE.
      at_cycle(f4 + 100);
      #1 run = 1'b0;
      at_cycle(f4 + 318);
      #1 run = 1'b1;
      exp_q[K_BSF].push_back(f4 + 319);
      f5 = f4 + 321;
      push_frame(f5, 10);
      at_cycle(f4 + 319);
      check("drain_race.busy", busy, 0);
      check("drain_race.h_cnt", h_cnt, 0);

      // ACTIVE with run dropped on the last-pixel edge wraps, then drains.
      at_cycle(f5 + 318);
      #1 run = 1'b0;
      f6 = f5 + 320;
      push_frame(f6, 10);
      exp_q[K_BSF].push_back(f6 + 319);
      at_cycle(f5 + 319);
      check("active_race.busy", busy, 1);
      check("active_race.h_cnt", h_cnt, 0);
      check("active_race.v_cnt", v_cnt, 0);
      at_cycle(f6 + 319);
      idle_chk("active_race_end");

      // Asynchronous reset at (6,3) aborts the frame.
      at_cycle(f6 + 330);
      #1 run = 1'b1;
      f7 = cyc + 2;
      push_frame(f7, 3);
      spot("pre_abort", f7 + 108, 6, 3, 1, 1, 1);
      #1 reset = 1'b0;
      run = 1'b0;
      exp_q[K_BSF].push_back(f7 + 109);
      #1 idle_chk("async_abort");
`ifdef FRAME_CNT_EN
      check("abort.frame_cnt", frame_cnt, 0);
`endif
      at_cycle(f7 + 112);
      idle_chk("reset_hold");
      #1 reset = 1'b1;
      at_cycle(f7 + 120);
      idle_chk("post_reset_idle");

      // Restart after reset, then drain that frame.
      #1 run = 1'b1;
      f8 = cyc + 2;
      push_frame(f8, 10);
      at_cycle(f8 + 4);
      #1 run = 1'b0;
      exp_q[K_BSF].push_back(f8 + 319);
      at_cycle(f8 + 330);
      idle_chk("final_idle");

      for (int k = 0; k < 6; k++) begin
         check($sformatf("pending_events_%0d", k), exp_q[k].size(), 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (pixel/line counts; totals H_TOT=800, V_TOT=525).
REQ-002 SHALL have ports:
- clk_in  input  1  board clock, 50 MHz, single clock domain.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  high = generate frames; low = stop at end of current frame.
- pix_en  output  1  pixel-rate clock enable (clk_in/2), one clk_in cycle wide.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- video_on  output  1  high while (h_cnt, v_cnt) is inside the active area.
- h_cnt  output  10  current pixel column, 0..799.
- v_cnt  output  10  current line, 0..524.
- frame_start  output  1  one-cycle pulse marking pixel (0,0).
- busy  output  1  high while a frame is in progress (state ACTIVE or DRAIN).
- frame_cnt  output  16  frames completed (present only with FRAME_CNT_EN).

Function
REQ-003 SHALL implement states IDLE, ACTIVE, DRAIN in a registered state machine.
REQ-004 IDLE: h_cnt=v_cnt=0, pix_en=0, hsync=vsync=1, video_on=0, busy=0; run=1 -> ACTIVE next clk_in edge.
REQ-005 ACTIVE: run=0 -> DRAIN; at the last pixel (799,524) with pix_en, counters wrap to (0,0) and stay ACTIVE.
REQ-006 DRAIN: run=1 -> ACTIVE without restarting counters; pixel (799,524) with pix_en -> IDLE.
REQ-007 Internal phase bit SHALL be 0 in IDLE and toggle every clk_in in ACTIVE/DRAIN; pix_en = phase bit, so the first pix_en occurs on the 2nd clk_in cycle after entering ACTIVE from IDLE.
REQ-008 h_cnt SHALL advance by 1 on each clk_in edge where pix_en=1; 799 wraps to 0 and increments v_cnt; v_cnt 524 wraps to 0.
REQ-009 hsync SHALL be 0 exactly when 656 <= h_cnt <= 751; vsync 0 exactly when 490 <= v_cnt <= 491.
REQ-010 video_on SHALL be 1 exactly when h_cnt < 640 and v_cnt < 480 and state != IDLE.
REQ-011 hsync, vsync, video_on SHALL be registered and valid in the same cycle as the h_cnt/v_cnt values they describe (no skew between counters and decodes).
REQ-012 frame_start SHALL be 1 for exactly the one clk_in cycle where pix_en=1 and (h_cnt,v_cnt)=(0,0), including the first frame after IDLE.
REQ-013 run toggling in the same cycle as the last-pixel pix_en: transition follows the state before that edge (ACTIVE wraps, DRAIN goes IDLE).
REQ-014 Counter widths SHALL not overflow; comparisons use unsigned 10-bit values.

Reset
REQ-015 reset=0 SHALL asynchronously force state IDLE, phase 0, all outputs to IDLE values, frame_cnt=0.
REQ-016 Reset deassertion SHALL be followed by IDLE until run=1 is sampled; reset mid-frame aborts the frame with no further pulses.

Configuration
REQ-017 With FRAME_CNT_EN defined: frame_cnt SHALL increment (wrapping 65535->0) on each pix_en at (799,524); without it the frame_cnt port and logic SHALL be absent.

Verification
REQ-018 Reset release, run=1 held -> first pix_en on 2nd clk_in after ACTIVE entry, frame_start coincident, h_cnt=0, v_cnt=0.
REQ-019 Steady run -> hsync low for 192 clk_in cycles per line, line period 1600 clk_in, vsync low for 3200 clk_in, frame period 840000 clk_in.
REQ-020 run dropped at (100,200) -> busy stays 1 until pixel (799,524) completes, then IDLE, h_cnt=v_cnt=0, no further frame_start.
REQ-021 run dropped then re-raised mid-frame -> no counter discontinuity, next frame_start exactly 840000 clk_in after previous.
REQ-022 reset pulsed low at (300,100) -> all outputs at IDLE values immediately, no clk_in edge needed.
REQ-023 FRAME_CNT_EN defined, 3 full frames -> frame_cnt=3; frame_cnt preset near wrap (65535 via forced run) -> wraps to 0.
